ddr_sram_ctrl: RTL and testbench

Memory-side controller that serves the core's DDR request port: single 64-bit loads, masked 64-bit stores and 512-bit instruction bursts. It sits directly downstream of the core's channel arbiter and translates each request into accesses on a single-port 64-bit synchronous SRAM, adding a programmable access latency. It owns the `ddr_ready` / `ddr_operation_done` handshake the arbiter waits on.

---
 rtl/ddr_sram_ctrl.sv | 149 ++++++++++++++
 tb/tb_ddr_sram_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_sram_ctrl.sv
// DDR request port to single-port 64-bit SRAM bridge: loads, masked stores, 8-beat bursts.
// Optional DDR_SRAM_CTRL_PERF_EN adds per-kind completion counters.
module ddr_sram_ctrl #(
  parameter int LATENCY = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         ddr_chip_enable,
  input  logic [18:0]  ddr_index,
  input  logic         ddr_write_enable,
  input  logic         ddr_burst_mode,
  input  logic [63:0]  ddr_opstore_write_mask,
  input  logic [63:0]  ddr_opstore_write_data,
  output logic [63:0]  ddr_opload_read_data,
  output logic [511:0] ddr_pc_read_inst,
  output logic         ddr_operation_done,
  output logic         ddr_ready,
  output logic         sram_en,
  output logic         sram_we,
  output logic [18:0]  sram_addr,
  output logic [63:0]  sram_wmask,
  output logic [63:0]  sram_wdata,
  input  logic [63:0]  sram_rdata
`ifdef DDR_SRAM_CTRL_PERF_EN
  ,
  output logic [31:0]  perf_load_cnt,
  output logic [31:0]  perf_store_cnt,
  output logic [31:0]  perf_burst_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, WAIT, ACCESS, COLLECT, DONE} state_t;

  localparam bit         SKIP_WAIT = (LATENCY == 0);
  localparam logic [3:0] LAT_LAST  = SKIP_WAIT ? 4'd0 : 4'(LATENCY - 1);

  state_t        state, state_nxt;
  logic          accept;
  logic [18:0]   req_idx;
  logic          req_we, req_burst;
  logic [63:0]   req_mask, req_data;
  logic [3:0]    wcnt;
  logic [2:0]    beat;
  logic          rd_pend;
  logic [2:0]    rd_beat;
  logic [6:0][63:0] burst_buf;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    accept             = 1'b0;
    ddr_ready          = 1'b0;
    ddr_operation_done = 1'b0;
    sram_en            = 1'b0;
    sram_we            = 1'b0;
    sram_addr          = '0;
    sram_wmask         = '0;
    sram_wdata         = '0;
    case (state)
      IDLE: begin
        ddr_ready = 1'b1;
        accept    = ddr_chip_enable;
        if (accept) state_nxt = SKIP_WAIT ? ACCESS : WAIT;
      end
      WAIT: if (wcnt == LAT_LAST) state_nxt = ACCESS;
      ACCESS: begin
        sram_en = 1'b1;
        if (req_we) begin
          sram_we    = 1'b1;
          sram_addr  = req_idx;
          sram_wmask = req_mask;
          sram_wdata = req_data;
          state_nxt  = DONE;
        end else if (req_burst) begin
          // beat counter wraps inside the aligned 8-word line
          sram_addr = {req_idx[18:3], beat};
          if (beat == 3'd7) state_nxt = COLLECT;
        end else begin
          sram_addr = req_idx;
          state_nxt = COLLECT;
        end
      end
      COLLECT: state_nxt = DONE;
      DONE: begin
        ddr_ready          = 1'b1;
        ddr_operation_done = 1'b1;
        accept             = ddr_chip_enable;
        state_nxt          = accept ? (SKIP_WAIT ? ACCESS : WAIT) : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_idx              <= '0;
      req_we               <= 1'b0;
      req_burst            <= 1'b0;
      req_mask             <= '0;
      req_data             <= '0;
      wcnt                 <= '0;
      beat                 <= '0;
      rd_pend              <= 1'b0;
      rd_beat              <= '0;
      burst_buf            <= '0;
      ddr_opload_read_data <= '0;
      ddr_pc_read_inst     <= '0;
    end else begin
      rd_pend <= sram_en & ~sram_we;
      rd_beat <= beat;
      if (accept) begin
        req_idx   <= ddr_index;
        req_we    <= ddr_write_enable;
        req_burst <= ~ddr_write_enable & ddr_burst_mode;
        req_mask  <= ddr_opstore_write_mask;
        req_data  <= ddr_opstore_write_data;
        wcnt      <= '0;
        beat      <= '0;
      end
      if (state == WAIT) wcnt <= wcnt + 4'd1;
      if (state == ACCESS && req_burst) beat <= beat + 3'd1;
      // beats 0..6 are staged; beat 7 arrives in COLLECT and commits with the rest
      if (rd_pend && req_burst && rd_beat != 3'd7) burst_buf[rd_beat] <= sram_rdata;
      if (state == COLLECT) begin
        if (req_burst) ddr_pc_read_inst     <= {sram_rdata, burst_buf};
        else           ddr_opload_read_data <= sram_rdata;
      end
    end
  end

`ifdef DDR_SRAM_CTRL_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_load_cnt  <= '0;
      perf_store_cnt <= '0;
      perf_burst_cnt <= '0;
    end else if (state == DONE) begin
      if (req_we)         perf_store_cnt <= perf_store_cnt + 32'd1;
      else if (req_burst) perf_burst_cnt <= perf_burst_cnt + 32'd1;
      else                perf_load_cnt  <= perf_load_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_sram_ctrl.sv
// Scoreboard bench for ddr_sram_ctrl: LATENCY=4 main instance plus a LATENCY=0 instance.
module tb_ddr_sram_ctrl;
  localparam int LAT = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic         ce = 1'b0, we = 1'b0, bm = 1'b0;
  logic [18:0]  idx = '0;
  logic [63:0]  wmask = '0, wdata = '0;
  logic [63:0]  ld_data;
  logic [511:0] pc_inst;
  logic         done, ready;
  logic         sram_en, sram_we;
  logic [18:0]  sram_addr;
  logic [63:0]  sram_wmask, sram_wdata, sram_rdata;

  logic         ce0 = 1'b0, we0 = 1'b0, bm0 = 1'b0;
  logic [18:0]  idx0 = '0;
  logic [63:0]  wmask0 = '0, wdata0 = '0;
  logic [63:0]  ld0;
  logic [511:0] pc0;
  logic         done0, ready0, en0, sw0;
  logic [18:0]  addr0;
  logic [63:0]  wm0, wd0, rd0;
`ifdef DDR_SRAM_CTRL_PERF_EN
  logic [31:0]  pl, ps, pb, pl0, ps0, pb0;
`endif

  ddr_sram_ctrl #(.LATENCY(LAT)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .ddr_chip_enable(ce), .ddr_index(idx), .ddr_write_enable(we), .ddr_burst_mode(bm),
    .ddr_opstore_write_mask(wmask), .ddr_opstore_write_data(wdata),
    .ddr_opload_read_data(ld_data), .ddr_pc_read_inst(pc_inst),
    .ddr_operation_done(done), .ddr_ready(ready),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
`ifdef DDR_SRAM_CTRL_PERF_EN
    , .perf_load_cnt(pl), .perf_store_cnt(ps), .perf_burst_cnt(pb)
`endif
  );

  ddr_sram_ctrl #(.LATENCY(0)) u_dut0 (
    .clock(clock), .reset_n(reset_n),
    .ddr_chip_enable(ce0), .ddr_index(idx0), .ddr_write_enable(we0), .ddr_burst_mode(bm0),
    .ddr_opstore_write_mask(wmask0), .ddr_opstore_write_data(wdata0),
    .ddr_opload_read_data(ld0), .ddr_pc_read_inst(pc0),
    .ddr_operation_done(done0), .ddr_ready(ready0),
    .sram_en(en0), .sram_we(sw0), .sram_addr(addr0),
    .sram_wmask(wm0), .sram_wdata(wd0), .sram_rdata(rd0)
`ifdef DDR_SRAM_CTRL_PERF_EN
    , .perf_load_cnt(pl0), .perf_store_cnt(ps0), .perf_burst_cnt(pb0)
`endif
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] init_val(input int i);
    if (i >= 'h28 && i <= 'h2F) return 64'(i - 'h27);
    if (i == 'h10) return 64'hDEADBEEF_CAFEF00D;
    return {32'h5A5A0000 | 32'(i), 32'hC3C30000 | 32'(i * 7)};
  endfunction

  // SRAM models: 64 words for the main instance, address-derived data for the LATENCY=0 one
  logic [63:0] mem [64];
  bit mem_init = 1'b0;
  always @(posedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else if (sram_en) begin
      if (sram_we) mem[sram_addr[5:0]] <= (mem[sram_addr[5:0]] & ~sram_wmask) | (sram_wdata & sram_wmask);
      else         sram_rdata <= mem[sram_addr[5:0]];
    end
  end
  always @(posedge clock) if (en0) rd0 <= {45'h0, addr0} ^ 64'hA5A5_0000_0000_5A5A;

  typedef struct { int cyc; logic w; logic [18:0] addr; logic [63:0] mask, data; } acc_t;
  typedef struct { int cyc; logic [63:0] ld; logic [511:0] pc; int kind; } res_t;
  acc_t acc_q[$];
  res_t res_q[$];
  logic [63:0]  ref_mem [64];
  logic [63:0]  exp_ld = '0;
  logic [511:0] exp_pc = '0;
  logic [63:0]  cur_ld = '0;
  logic [511:0] cur_pc = '0;
  int cnt_m [3];

  always @(negedge clock) begin
    if (!reset_n) begin
      cur_ld = '0; cur_pc = '0;
      for (int k = 0; k < 3; k++) cnt_m[k] = 0;
    end else begin
      acc_t a;
      res_t r;
      chk("ready", ready, (res_q.size() == 0) || (cyc >= res_q[0].cyc));
      if (acc_q.size() > 0 && cyc > acc_q[0].cyc) begin
        a = acc_q.pop_front();
        chk("acc_missing", cyc, a.cyc);
      end
      if (sram_en) begin
        chk("acc_expected", acc_q.size() > 0, 1'b1);
        if (acc_q.size() > 0) begin
          a = acc_q.pop_front();
          chk("acc_cyc", cyc, a.cyc);
          chk("acc_addr", sram_addr, a.addr);
          chk("acc_we", sram_we, a.w);
          if (a.w) begin
            chk("acc_mask", sram_wmask, a.mask);
            chk("acc_data", sram_wdata, a.data);
          end
        end
      end else begin
        chk("sram_idle", {sram_we, sram_addr, sram_wmask, sram_wdata}, '0);
      end
      if (done) begin
        chk("done_expected", res_q.size() > 0, 1'b1);
        if (res_q.size() > 0) begin
          r = res_q.pop_front();
          chk("done_cyc", cyc, r.cyc);
          chk("ld_data", ld_data, r.ld);
          chk("pc_inst", pc_inst, r.pc);
          cur_ld = r.ld; cur_pc = r.pc;
          cnt_m[r.kind]++;
        end
      end else begin
        if (res_q.size() > 0 && cyc > res_q[0].cyc) begin
          r = res_q.pop_front();
          chk("done_missing", cyc, r.cyc);
        end
        chk("ld_hold", ld_data, cur_ld);
        chk("pc_hold", pc_inst, cur_pc);
      end
    end
  end

  // kind: 0 load, 1 store, 2 burst
  task automatic do_req(input int kind, input logic [18:0] i, input logic [63:0] m, input logic [63:0] d,
                        output int t);
    int n;
    acc_t a;
    res_t r;
    n = 0;
    @(negedge clock);
    while (!ready && n < 50) begin @(negedge clock); n++; end
    chk("ready_wait", ready, 1'b1);
    ce = 1'b1; we = (kind == 1); bm = (kind != 0); idx = i; wmask = m; wdata = d;
    t = cyc;
    @(posedge clock);
    #1 ce = 1'b0;
    if (kind == 1) begin
      a = '{t + 1 + LAT, 1'b1, i, m, d};
      acc_q.push_back(a);
      ref_mem[i[5:0]] = (ref_mem[i[5:0]] & ~m) | (d & m);
      r = '{t + 2 + LAT, exp_ld, exp_pc, 1};
    end else if (kind == 2) begin
      for (int k = 0; k < 8; k++) begin
        a = '{t + 1 + LAT + k, 1'b0, {i[18:3], 3'(k)}, 64'h0, 64'h0};
        acc_q.push_back(a);
        exp_pc[64*k +: 64] = ref_mem[{i[5:3], 3'(k)}];
      end
      r = '{t + 10 + LAT, exp_ld, exp_pc, 2};
    end else begin
      a = '{t + 1 + LAT, 1'b0, i, 64'h0, 64'h0};
      acc_q.push_back(a);
      exp_ld = ref_mem[i[5:0]];
      r = '{t + 3 + LAT, exp_ld, exp_pc, 0};
    end
    res_q.push_back(r);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (res_q.size() > 0 && n < 100) begin @(negedge clock); n++; end
    chk("drain", res_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int t, en_c, dn_c;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    repeat (3) @(negedge clock);
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_ld", ld_data, '0);
    chk("rst_pc", pc_inst, '0);
    chk("rst_sram", {sram_en, sram_we, sram_addr, sram_wmask, sram_wdata}, '0);
    chk("rst_ready0", ready0, 1'b1);
    reset_n = 1'b1;

    // LATENCY=0 single load
    @(negedge clock);
    ce0 = 1'b1; idx0 = 19'h00123; t = cyc;
    @(posedge clock);
    #1 ce0 = 1'b0;
    en_c = -1; dn_c = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      if (en0 && en_c < 0) begin en_c = cyc; chk("l0_addr", addr0, 19'h00123); end
      if (done0 && dn_c < 0) dn_c = cyc;
    end
    chk("l0_strobe_cyc", en_c, t + 1);
    chk("l0_done_cyc", dn_c, t + 3);
    chk("l0_data", ld0, 64'hA5A5_0000_0000_5A5A ^ 64'h123);
`ifdef DDR_SRAM_CTRL_PERF_EN
    chk("l0_perf_load", pl0, 32'd1);
`endif

    // directed LATENCY=4 sequence
    do_req(0, 19'h00010, '0, '0, t);
    do_req(1, 19'h00010, 64'h00000000_FFFFFFFF, 64'h11223344_55667788, t);
    do_req(0, 19'h00010, '0, '0, t);
    do_req(2, 19'h0002B, '0, '0, t);
    // strobe while busy must be ignored
    @(negedge clock);
    @(negedge clock);
    ce = 1'b1; we = 1'b1; bm = 1'b0; idx = 19'h3; wmask = '1; wdata = 64'hBAD0BAD0BAD0BAD0;
    @(posedge clock);
    #1 ce = 1'b0;
    do_req(1, 19'h00005, 64'hFF00FF00_FF00FF00, 64'h0123456789ABCDEF, t);
    do_req(0, 19'h00003, '0, '0, t);

    for (int n = 0; n < 8; n++)
      do_req(int'($urandom_range(0, 2)), 19'($urandom_range(0, 63)), {$urandom, $urandom}, {$urandom, $urandom}, t);
    drain();

    // reset during burst beat 3
    do_req(2, 19'h00018, '0, '0, t);
    repeat (8) @(negedge clock);
    reset_n = 1'b0;
    #1;
    acc_q.delete();
    res_q.delete();
    exp_ld = '0; exp_pc = '0;
    chk("mid_rst_ready", ready, 1'b1);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_sram", {sram_en, sram_we, sram_addr, sram_wmask, sram_wdata}, '0);
    chk("mid_rst_ld", ld_data, '0);
    chk("mid_rst_pc", pc_inst, '0);
    for (int n = 0; n < 2; n++) begin
      @(negedge clock);
      chk("rst_no_done", done, 1'b0);
    end
    reset_n = 1'b1;

    // 2 loads, 1 store, 3 bursts after reset
    do_req(0, 19'h00028, '0, '0, t);
    do_req(1, 19'h0002A, 64'hFFFF0000_0000FFFF, 64'hA1A2A3A4_B1B2B3B4, t);
    do_req(2, 19'h0002F, '0, '0, t);
    do_req(0, 19'h0002A, '0, '0, t);
    do_req(2, 19'h00008, '0, '0, t);
    do_req(2, 19'h00039, '0, '0, t);
    drain();
    repeat (2) @(negedge clock);
    chk("acc_left", acc_q.size(), 0);
`ifdef DDR_SRAM_CTRL_PERF_EN
    chk("perf_load", pl, 32'd2);
    chk("perf_store", ps, 32'd1);
    chk("perf_burst", pb, 32'd3);
    chk("perf_model", {pl, ps, pb}, {32'(cnt_m[0]), 32'(cnt_m[1]), 32'(cnt_m[2])});
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
